// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame buffer manager: index width, writer
// states and the index-to-DDR-address mapping.
package fb_pkg;

  // Sized for the largest legal buffer count so all instances share one width.
  localparam int unsigned IDX_W = $clog2(4);

  typedef enum logic {
    WIdle   = 1'b0,
    WActive = 1'b1
  } wr_state_e;

  // Computed at 64 bits; callers cast down to their address width (wrap ignored).
  function automatic logic [63:0] idx_to_addr(input logic [63:0]      base,
                                              input logic [63:0]      stride,
                                              input logic [IDX_W-1:0] idx);
    return base + stride * 64'(idx);
  endfunction

endpackage

// File: rtl/fb_free_picker.sv
// Combinational choice of the next write buffer: lowest index that is neither
// being displayed nor holding the newest unread frame.
module fb_free_picker
  import fb_pkg::*;
#(
  parameter int unsigned NUM_BUFS = 3
) (
  input  logic [IDX_W-1:0] r_idx_i,
  input  logic [IDX_W-1:0] latest_idx_i,
  input  logic             latest_valid_i,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             collide_o
);

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] fallback_idx;

  // Walk downwards so the lowest qualifying index is the last one written.
  always_comb begin
    free_idx     = '0;
    fallback_idx = '0;
    collide_o    = 1'b1;
    for (int i = int'(NUM_BUFS) - 1; i >= 0; i--) begin
      if (IDX_W'(i) != r_idx_i) begin
        fallback_idx = IDX_W'(i);
        if (!(latest_valid_i && (IDX_W'(i) == latest_idx_i))) begin
          free_idx  = IDX_W'(i);
          collide_o = 1'b0;
        end
      end
    end
    pick_idx_o = collide_o ? fallback_idx : free_idx;
  end

endmodule

// File: rtl/frame_buffer_manager.sv
// N-buffer frame pointer manager: rotates DDR frame bases between the AXI
// writer and reader, tracking dropped/repeated frames.
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter int unsigned        NUM_BUFS   = 3,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h1000_0000,
  parameter logic [ADDR_W-1:0]  BUF_STRIDE = 32'h0010_0000,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              clk_100Mhz,
  input  logic              sys_rst_n,
  input  logic              single_mode,
  input  logic              freeze,
  input  logic              wr_frame_start,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic              rd_has_frame,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [CNT_W-1:0]  frames_repeated,
  output logic              protocol_err
);

  localparam logic [ADDR_W-1:0] WrRstAddr = ADDR_W'(idx_to_addr(64'(BASE_ADDR),
                                                                64'(BUF_STRIDE), IDX_W'(1)));

  wr_state_e        state_q, state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [IDX_W-1:0] latest_idx_q, latest_idx_d;
  logic             latest_valid_q, latest_valid_d;
  logic             has_frame_q, has_frame_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic [CNT_W-1:0] repeated_q, repeated_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  // State after done and rd_frame_start have been applied, seen by the start logic.
  wr_state_e        mid_state;
  logic [IDX_W-1:0] mid_latest_idx;
  logic             mid_latest_valid;
  logic             drop_done, drop_start, rep_inc;
  logic [IDX_W-1:0] pick_idx;
  logic             collide;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    mid_state        = state_q;
    mid_latest_idx   = latest_idx_q;
    mid_latest_valid = latest_valid_q;
    r_idx_d          = r_idx_q;
    has_frame_d      = has_frame_q;
    perr_d           = perr_q;
    drop_done        = 1'b0;
    rep_inc          = 1'b0;
    if (wr_frame_done) begin
      if (state_q == WActive) begin
        drop_done        = latest_valid_q;
        mid_latest_idx   = w_idx_q;
        mid_latest_valid = 1'b1;
        mid_state        = WIdle;
      end else begin
        perr_d = 1'b1;
      end
    end
    if (rd_frame_start) begin
      if (mid_latest_valid && !freeze) begin
        r_idx_d          = mid_latest_idx;
        mid_latest_valid = 1'b0;
        has_frame_d      = 1'b1;
      end else begin
        rep_inc = 1'b1;
      end
    end
  end

  fb_free_picker #(
    .NUM_BUFS (NUM_BUFS)
  ) u_picker (
    .r_idx_i        (r_idx_d),
    .latest_idx_i   (mid_latest_idx),
    .latest_valid_i (mid_latest_valid),
    .pick_idx_o     (pick_idx),
    .collide_o      (collide)
  );

  always_comb begin
    state_d        = mid_state;
    w_idx_d        = w_idx_q;
    latest_idx_d   = mid_latest_idx;
    latest_valid_d = mid_latest_valid;
    drop_start     = 1'b0;
    if (wr_frame_start) begin
      if (mid_state == WActive) begin
        drop_start = 1'b1;
      end else begin
        w_idx_d = pick_idx;
        // Only two buffers: the unread frame must be sacrificed for the new one.
        if (collide) begin
          latest_valid_d = 1'b0;
          drop_start     = 1'b1;
        end
      end
      state_d = WActive;
    end

    dropped_d  = sat_add(dropped_q, {1'b0, drop_done} + {1'b0, drop_start});
    repeated_d = sat_add(repeated_q, {1'b0, rep_inc});

    // Addresses (and the mode select) only move on an event pulse.
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    if (wr_frame_start || wr_frame_done || rd_frame_start) begin
      if (single_mode) begin
        rd_addr_d = BASE_ADDR;
        wr_addr_d = BASE_ADDR;
      end else begin
        rd_addr_d = ADDR_W'(idx_to_addr(64'(BASE_ADDR), 64'(BUF_STRIDE), r_idx_d));
        wr_addr_d = ADDR_W'(idx_to_addr(64'(BASE_ADDR), 64'(BUF_STRIDE), w_idx_d));
      end
    end
  end

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= WIdle;
      w_idx_q        <= IDX_W'(1);
      r_idx_q        <= '0;
      latest_idx_q   <= '0;
      latest_valid_q <= 1'b0;
      has_frame_q    <= 1'b0;
      perr_q         <= 1'b0;
      dropped_q      <= '0;
      repeated_q     <= '0;
      rd_addr_q      <= BASE_ADDR;
      wr_addr_q      <= WrRstAddr;
    end else begin
      state_q        <= state_d;
      w_idx_q        <= w_idx_d;
      r_idx_q        <= r_idx_d;
      latest_idx_q   <= latest_idx_d;
      latest_valid_q <= latest_valid_d;
      has_frame_q    <= has_frame_d;
      perr_q         <= perr_d;
      dropped_q      <= dropped_d;
      repeated_q     <= repeated_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
    end
  end

  assign wr_base_addr    = wr_addr_q;
  assign rd_base_addr    = rd_addr_q;
  assign rd_has_frame    = has_frame_q;
  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;
  assign protocol_err    = perr_q;

  a_no_overlap: assert property (@(posedge clk_100Mhz) disable iff (!sys_rst_n)
                                 (state_q == WActive) |-> (w_idx_q != r_idx_q));

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Bench: three instances (3 buffers, 2 buffers, 3 buffers with 4-bit counters)
// driven in lockstep; directed table, corner sequences and random traffic.
module tb_frame_buffer_manager;

  localparam logic [31:0] Base   = 32'h1000_0000;
  localparam logic [31:0] Stride = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic single_mode = 1'b0, freeze = 1'b0;
  logic ws = 1'b0, wd = 1'b0, rs = 1'b0;

  logic [31:0] wr3, rd3, wr2, rd2, wrs, rds;
  logic        has3, has2, hass, pe3, pe2, pes;
  logic [15:0] drop3, rep3, drop2, rep2;
  logic [3:0]  drops, reps;

  always #5 clk = ~clk;

  frame_buffer_manager #(.NUM_BUFS(3)) dut3 (
    .clk_100Mhz(clk), .sys_rst_n(rst_n), .single_mode(single_mode), .freeze(freeze),
    .wr_frame_start(ws), .wr_frame_done(wd), .rd_frame_start(rs),
    .wr_base_addr(wr3), .rd_base_addr(rd3), .rd_has_frame(has3),
    .frames_dropped(drop3), .frames_repeated(rep3), .protocol_err(pe3));

  frame_buffer_manager #(.NUM_BUFS(2)) dut2 (
    .clk_100Mhz(clk), .sys_rst_n(rst_n), .single_mode(single_mode), .freeze(freeze),
    .wr_frame_start(ws), .wr_frame_done(wd), .rd_frame_start(rs),
    .wr_base_addr(wr2), .rd_base_addr(rd2), .rd_has_frame(has2),
    .frames_dropped(drop2), .frames_repeated(rep2), .protocol_err(pe2));

  frame_buffer_manager #(.NUM_BUFS(3), .CNT_W(4)) duts (
    .clk_100Mhz(clk), .sys_rst_n(rst_n), .single_mode(single_mode), .freeze(freeze),
    .wr_frame_start(ws), .wr_frame_done(wd), .rd_frame_start(rs),
    .wr_base_addr(wrs), .rd_base_addr(rds), .rd_has_frame(hass),
    .frames_dropped(drops), .frames_repeated(reps), .protocol_err(pes));

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance buffer bookkeeping; latest = -1 means none ready.
  int          m_n[3]   = '{3, 2, 3};
  int          m_max[3] = '{65535, 65535, 15};
  bit          m_busy[3];
  int          m_w[3], m_r[3], m_latest[3], m_drop[3], m_rep[3];
  bit          m_has[3], m_perr[3];
  logic [31:0] m_rda[3], m_wra[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_w[k] = 1; m_r[k] = 0; m_latest[k] = -1;
      m_drop[k] = 0; m_rep[k] = 0; m_has[k] = 0; m_perr[k] = 0;
      m_rda[k] = Base; m_wra[k] = Base + Stride;
    end
  endtask

  task automatic model_step(input bit s, input bit d, input bit r, input bit frz, input bit sgl);
    for (int k = 0; k < 3; k++) begin
      if (d) begin
        if (m_busy[k]) begin
          if (m_latest[k] >= 0 && m_drop[k] < m_max[k]) m_drop[k]++;
          m_latest[k] = m_w[k];
          m_busy[k] = 0;
        end else m_perr[k] = 1;
      end
      if (r) begin
        if (m_latest[k] >= 0 && !frz) begin
          m_r[k] = m_latest[k]; m_latest[k] = -1; m_has[k] = 1;
        end else if (m_rep[k] < m_max[k]) m_rep[k]++;
      end
      if (s) begin
        if (m_busy[k]) begin
          if (m_drop[k] < m_max[k]) m_drop[k]++;
        end else begin
          int pick = -1;
          for (int i = m_n[k] - 1; i >= 0; i--)
            if (i != m_r[k] && i != m_latest[k]) pick = i;
          if (pick < 0) begin
            for (int i = m_n[k] - 1; i >= 0; i--) if (i != m_r[k]) pick = i;
            m_latest[k] = -1;
            if (m_drop[k] < m_max[k]) m_drop[k]++;
          end
          m_w[k] = pick;
        end
        m_busy[k] = 1;
      end
      if (s || d || r) begin
        m_rda[k] = sgl ? Base : Base + Stride * m_r[k];
        m_wra[k] = sgl ? Base : Base + Stride * m_w[k];
      end
    end
  endtask

  task automatic cmp_model(input int k);
    logic [31:0] ra, wa, dr, rp;
    logic        hf, pe;
    case (k)
      0:       begin ra = rd3; wa = wr3; hf = has3; dr = 32'(drop3); rp = 32'(rep3); pe = pe3; end
      1:       begin ra = rd2; wa = wr2; hf = has2; dr = 32'(drop2); rp = 32'(rep2); pe = pe2; end
      default: begin ra = rds; wa = wrs; hf = hass; dr = 32'(drops); rp = 32'(reps); pe = pes; end
    endcase
    chk($sformatf("inst%0d rd_base_addr", k), ra, m_rda[k]);
    chk($sformatf("inst%0d wr_base_addr", k), wa, m_wra[k]);
    chk($sformatf("inst%0d rd_has_frame", k), 32'(hf), 32'(m_has[k]));
    chk($sformatf("inst%0d frames_dropped", k), dr, 32'(m_drop[k]));
    chk($sformatf("inst%0d frames_repeated", k), rp, 32'(m_rep[k]));
    chk($sformatf("inst%0d protocol_err", k), 32'(pe), 32'(m_perr[k]));
  endtask

  // Called at a negedge; applies one cycle of pulses and returns at the next negedge.
  task automatic step(input bit s, input bit d, input bit r);
    ws = s; wd = d; rs = r;
    @(posedge clk);
    model_step(s, d, r, freeze, single_mode);
    @(negedge clk);
    ws = 1'b0; wd = 1'b0; rs = 1'b0;
    for (int k = 0; k < 3; k++) cmp_model(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s, d, r, sgl;
    logic [31:0] rda, wra;
    logic        has;
    int          drop, rep;
    logic        perr;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic s, input logic d, input logic r, input logic sgl,
                     input logic [31:0] rda, input logic [31:0] wra, input logic has,
                     input int drop, input int rep, input logic perr);
    vec_t v;
    v.s = s; v.d = d; v.r = r; v.sgl = sgl; v.rda = rda; v.wra = wra;
    v.has = has; v.drop = drop; v.rep = rep; v.perr = perr;
    vecs.push_back(v);
  endtask

  initial begin
    // Directed table for the 3-buffer instance.
    add(1, 0, 0, 0, 32'h1000_0000, 32'h1010_0000, 0, 0, 0, 0);
    add(0, 1, 0, 0, 32'h1000_0000, 32'h1010_0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h1010_0000, 32'h1010_0000, 1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h1010_0000, 32'h1000_0000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 32'h1010_0000, 32'h1000_0000, 1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h1010_0000, 32'h1020_0000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 32'h1010_0000, 32'h1020_0000, 1, 1, 0, 0);
    add(0, 0, 1, 0, 32'h1020_0000, 32'h1020_0000, 1, 1, 0, 0);
    add(0, 0, 1, 0, 32'h1020_0000, 32'h1020_0000, 1, 1, 1, 0);
    add(0, 1, 0, 0, 32'h1020_0000, 32'h1020_0000, 1, 1, 1, 1);
    add(1, 0, 0, 0, 32'h1020_0000, 32'h1000_0000, 1, 1, 1, 1);
    add(0, 1, 1, 0, 32'h1000_0000, 32'h1000_0000, 1, 1, 1, 1);
    add(1, 0, 0, 0, 32'h1000_0000, 32'h1010_0000, 1, 1, 1, 1);
    add(1, 0, 0, 0, 32'h1000_0000, 32'h1010_0000, 1, 2, 1, 1);
    add(0, 0, 1, 1, 32'h1000_0000, 32'h1000_0000, 1, 2, 2, 1);
    add(0, 0, 0, 0, 32'h1000_0000, 32'h1000_0000, 1, 2, 2, 1);
    add(0, 1, 0, 0, 32'h1000_0000, 32'h1010_0000, 1, 2, 2, 1);

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset rd_base_addr", rd3, 32'h1000_0000);
    chk("reset wr_base_addr", wr3, 32'h1010_0000);
    chk("reset rd_has_frame", 32'(has3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) cmp_model(k);

    foreach (vecs[i]) begin
      single_mode = vecs[i].sgl;
      step(vecs[i].s, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d rd_base_addr", i), rd3, vecs[i].rda);
      chk($sformatf("vec%0d wr_base_addr", i), wr3, vecs[i].wra);
      chk($sformatf("vec%0d rd_has_frame", i), 32'(has3), 32'(vecs[i].has));
      chk($sformatf("vec%0d frames_dropped", i), 32'(drop3), 32'(vecs[i].drop));
      chk($sformatf("vec%0d frames_repeated", i), 32'(rep3), 32'(vecs[i].rep));
      chk($sformatf("vec%0d protocol_err", i), 32'(pe3), 32'(vecs[i].perr));
    end
    single_mode = 1'b0;

    // Freeze holds the reader on its buffer while a frame is ready.
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("freeze rd_base_addr", rd3, 32'h1000_0000);
    chk("freeze frames_repeated", 32'(rep3), 32'd5);
    freeze = 1'b0;
    step(0, 0, 1);
    chk("unfreeze rd_base_addr", rd3, 32'h1010_0000);

    // Two buffers: restart before a read reuses the same buffer and drops the ready one.
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("nb2 frames_dropped", 32'(drop2), 32'd1);
    chk("nb2 wr_base_addr", wr2, 32'h1010_0000);
    step(0, 0, 1);
    chk("nb2 no ready frame rd_base_addr", rd2, 32'h1000_0000);
    chk("nb2 frames_repeated", 32'(rep2), 32'd1);

    // Asynchronous reset mid-frame returns to reset values without crediting the frame.
    step(0, 1, 0);
    step(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset rd_base_addr", rd3, 32'h1000_0000);
    chk("midreset wr_base_addr", wr3, 32'h1010_0000);
    chk("midreset frames_dropped", 32'(drop3), 32'd0);
    chk("midreset protocol_err", 32'(pe3), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0);
    chk("midreset late done protocol_err", 32'(pe3), 32'd1);

    // Random traffic against the model; counters on the narrow instance saturate.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 5) freeze = ~freeze;
      if ($urandom_range(99) < 2) single_mode = ~single_mode;
      if ($urandom_range(999) < 3) do_reset();
      step($urandom_range(99) < 30, $urandom_range(99) < 30, $urandom_range(99) < 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_manager.md
# frame_buffer_manager

Parametrised N-buffer frame-pointer manager for the camera-to-DDR-to-HDMI video path, clocked in the AXI domain. It hands the AXI writer a DDR base address per captured frame and the AXI reader the base address of the newest completed frame at each display frame start. This removes tearing and single-buffer overwrite. It counts dropped and repeated frames and supports a freeze (hold-display) mode and a legacy single-buffer mode.

## Interface
- NUM_BUFS, 3, number of frame buffers, legal 2..4
- ADDR_W, 32, address width
- BASE_ADDR, 32'h1000_0000, DDR address of buffer 0
- BUF_STRIDE, 32'h0010_0000, byte distance between buffers; must be ≥ frame size (640x480x2 = 614400)
- CNT_W, 16, width of statistics counters

- clk_100Mhz  in  1  AXI-domain clock
- sys_rst_n  in  1  asynchronous, active-low reset
- single_mode  in  1  1 = legacy mode: both addresses fixed at BASE_ADDR, no pointer rotation
- freeze  in  1  1 = reader keeps its current buffer; writer keeps rotating
- wr_frame_start  in  1  one-cycle pulse: writer begins a frame (already synchronised to clk_100Mhz)
- wr_frame_done  in  1  one-cycle pulse: writer received the last BVALID of the frame
- rd_frame_start  in  1  one-cycle pulse: reader needs a buffer for the next display frame
- wr_base_addr  out  ADDR_W  base address for the current or next write frame
- rd_base_addr  out  ADDR_W  base address for the current display frame
- rd_has_frame  out  1  at least one completed frame has been handed to the reader
- frames_dropped  out  CNT_W  saturating count of frames lost
- frames_repeated  out  CNT_W  saturating count of display frames with no new buffer
- protocol_err  out  1  sticky; set on wr_frame_done while the writer is idle

## Operation
- Registered state:
  - w_idx, r_idx, latest_idx (each clog2(NUM_BUFS) bits)
  - latest_valid
  - writer FSM W_IDLE / W_ACTIVE
- Reset values:
  - r_idx=0, w_idx=1, latest_valid=0, FSM=W_IDLE
  - rd_base_addr=BASE_ADDR, wr_base_addr=BASE_ADDR+BUF_STRIDE
  - rd_has_frame=0, counters=0, protocol_err=0
- Addresses: addr = BASE_ADDR + idx*BUF_STRIDE, computed ADDR_W-wide with wrap ignored.
- rd_frame_start:
  - If latest_valid && !freeze: r_idx←latest_idx, latest_valid←0, rd_has_frame←1.
  - Otherwise: frames_repeated++.
- wr_frame_start:
  - In W_ACTIVE, the previous frame is aborted: frames_dropped++ and w_idx is reused.
  - In W_IDLE: w_idx←lowest index ≠ r_idx and ≠ latest_idx (when latest_valid).
  - If no such index exists (NUM_BUFS=2 case): pick the lowest index ≠ r_idx, clear latest_valid, frames_dropped++.
  - FSM→W_ACTIVE.
- wr_frame_done:
  - In W_ACTIVE: if latest_valid, frames_dropped++ (an unread ready frame is superseded); then latest_idx←w_idx, latest_valid←1, FSM→W_IDLE.
  - In W_IDLE: ignored, protocol_err←1.
- Simultaneous events, in evaluation order within one cycle:
  - done before rd_frame_start: the reader receives the just-completed frame.
  - rd_frame_start before wr_frame_start: writer selection excludes the new r_idx.
  - wr_frame_done together with wr_frame_start: done completes first, then a new frame starts.
- Invariant: w_idx ≠ r_idx whenever the FSM is W_ACTIVE. Checked by assertion.
- single_mode=1: both outputs are BASE_ADDR; counters and FSM still run. Changing the mode takes effect on the next event pulse.

## Timing
- All outputs registered; addresses valid 1 cycle after the triggering pulse.
- Consumers sample wr_base_addr/rd_base_addr no earlier than 2 cycles after their own start pulse.
- Counters saturate at 2^CNT_W−1; no wrap.
- Reset is asynchronous assert with synchronous deassert handled upstream. Reset mid-frame returns all state to reset values in the same edge, with no completion credited.

## Structure
- Package fb_pkg:
  - IDX_W = clog2(4)
  - writer FSM state constants
  - function idx_to_addr(base, stride, idx)
- Sub-module fb_free_picker: combinational. Inputs r_idx, latest_idx, latest_valid, NUM_BUFS. Outputs pick_idx and collide. Instantiated once.
- Top module holds the FSM, pointer registers, counters and address registers; roughly 200 lines total.

## Test plan
- Reset, NUM_BUFS=3 → rd_base_addr=0x1000_0000, wr_base_addr=0x1010_0000, rd_has_frame=0.
- wr start/done to buffer 1, then rd_frame_start → rd_base_addr=0x1010_0000 after 1 cycle. Next wr_frame_start selects buffer 0 → wr_base_addr=0x1000_0000.
- Two complete writes with no rd_frame_start, NUM_BUFS=3 → frames_dropped=1. Reader then gets the second buffer.
- NUM_BUFS=2: write done, then wr_frame_start before any read → same index reused, latest_valid cleared, frames_dropped=1, w_idx never equals r_idx.
- freeze=1 with a ready frame: 5 rd_frame_start pulses → rd_base_addr unchanged, frames_repeated=5.
- wr_frame_done and rd_frame_start in the same cycle → reader gets the just-completed buffer. A lone extra wr_frame_done → protocol_err=1 and no pointer change.
